uart_cmd_responder: RTL and testbench

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

---
 rtl/uart_cmd_pkg.sv | 24 ++
 rtl/uart_cmd_regfile.sv | 26 ++
 rtl/uart_cmd_responder.sv | 175 +++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command responder.
// Opcodes, reply bytes and the FSM state enum live here.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_BAD  = 8'h3F;  // '?'
  localparam logic [7:0] RSP_PERR = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_EXEC,
    ST_SEND
  } state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// Four 8-bit registers: one synchronous write port, one combinational read port.
// All registers are also exposed flat, reg n at bits [8n+7:8n].
module uart_cmd_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  rdata_o,
  output logic [31:0] reg_out_o
);

  logic [3:0][7:0] regs_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '0;
    end else if (we_i) begin
      regs_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o   = regs_q[addr_i];
  assign reg_out_o = regs_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-oriented command responder: 'W' addr data writes a register, 'R' addr reads one,
// every command ends in a one-byte reply. Optional parity abort: UART_CMD_PARITY_CHK_EN.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_READY,
  input  logic        RX_PARITY_ERR,
  input  logic        TX_READY,
  output logic        TX_START,
  output logic [7:0]  TX_DATA,
  output logic [31:0] REG_OUT,
  output logic        BUSY,
  output logic        OVERRUN,
  output state_e      DBG_STATE
);

  // Handshakes: a received byte is the rising edge of the RX_READY level (one byte per
  // edge, RX_DATA valid with it). In SEND, TX_START rises once TX_READY is high and
  // stays high until TX_READY is seen low, which marks the byte as taken.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            rx_prev_q;
  logic            rx_new;
  logic            in_get;
  logic            timeout;
  logic            parity_abort;
  logic [7:0]      opcode_q, opcode_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      reply_q, reply_d;
  logic            tx_start_q, tx_start_d;
  logic            overrun_q, overrun_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            reg_we;
  logic [7:0]      rd_data;

  assign rx_new  = RX_READY & ~rx_prev_q;
  assign in_get  = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign timeout = (to_cnt_q >= TO_LAST);

`ifdef UART_CMD_PARITY_CHK_EN
  logic receiving;
  assign receiving    = (state_q == ST_IDLE) || in_get;
  assign parity_abort = rx_new & RX_PARITY_ERR & receiving;
`else
  logic unused_parity;
  assign unused_parity = RX_PARITY_ERR;
  assign parity_abort  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (parity_abort)                state_d = ST_SEND;
        else if (rx_new && is_opcode(RX_DATA)) state_d = ST_GET_ADDR;
        else if (rx_new)                 state_d = ST_SEND;
      end
      ST_GET_ADDR: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (parity_abort)  state_d = ST_SEND;
        else if (rx_new)   state_d = (opcode_q == OP_WRITE) ? ST_GET_DATA : ST_EXEC;
        else if (timeout)  state_d = ST_IDLE;
      end
      ST_GET_DATA: begin
        if (parity_abort)  state_d = ST_SEND;
        else if (rx_new)   state_d = ST_EXEC;
        else if (timeout)  state_d = ST_IDLE;
      end
      ST_EXEC: state_d = ST_SEND;
      ST_SEND: begin
        if (tx_start_q && !TX_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    data_d     = data_q;
    reply_d    = reply_q;
    tx_start_d = tx_start_q;
    reg_we     = 1'b0;
    overrun_d  = overrun_q | (rx_new & ((state_q == ST_EXEC) || (state_q == ST_SEND)));
    if (rx_new || !in_get)       to_cnt_d = '0;
    else if (to_cnt_q != '1)     to_cnt_d = to_cnt_q + TO_W'(1);
    else                         to_cnt_d = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (parity_abort)                      reply_d  = RSP_PERR;
        else if (rx_new && is_opcode(RX_DATA)) opcode_d = RX_DATA;
        else if (rx_new)                       reply_d  = RSP_BAD;
      end
      ST_GET_ADDR: begin
        if (parity_abort)  reply_d = RSP_PERR;
        else if (rx_new)   addr_d  = RX_DATA;
      end
      ST_GET_DATA: begin
        if (parity_abort)  reply_d = RSP_PERR;
        else if (rx_new)   data_d  = RX_DATA;
      end
      ST_EXEC: begin
        if (addr_q[7:2] != 6'd0) begin
          reply_d = RSP_BAD;
        end else if (opcode_q == OP_WRITE) begin
          reg_we  = 1'b1;
          reply_d = RSP_OK;
        end else begin
          reply_d = rd_data;
        end
      end
      ST_SEND: begin
        if (!tx_start_q && TX_READY)      tx_start_d = 1'b1;
        else if (tx_start_q && !TX_READY) tx_start_d = 1'b0;
      end
      default: ;
    endcase
  end

  // The RX_READY delay register resets high so a level held across reset is not a byte.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_prev_q  <= 1'b1;
      opcode_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      reply_q    <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      rx_prev_q  <= RX_READY;
      opcode_q   <= opcode_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      reply_q    <= reply_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  uart_cmd_regfile u_regfile (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .we_i      (reg_we),
    .addr_i    (addr_q[1:0]),
    .wdata_i   (data_q),
    .rdata_o   (rd_data),
    .reg_out_o (REG_OUT)
  );

  assign TX_START  = tx_start_q;
  assign TX_DATA   = reply_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign OVERRUN   = overrun_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: directed protocol cases plus random command streams,
// checked against a byte-level command model with an expected-reply queue.
module tb_uart_cmd_responder;
  import uart_cmd_pkg::*;

  localparam int T = 40;

`ifdef UART_CMD_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_perr;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] reg_out;
  logic        busy;
  logic        overrun;
  state_e      dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_responder #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .RX_DATA       (rx_data),
    .RX_READY      (rx_ready),
    .RX_PARITY_ERR (rx_perr),
    .TX_READY      (tx_ready),
    .TX_START      (tx_start),
    .TX_DATA       (tx_data),
    .REG_OUT       (reg_out),
    .BUSY          (busy),
    .OVERRUN       (overrun),
    .DBG_STATE     (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] m_regs[4];
  int         m_phase;          // 0: expecting opcode, 1: address, 2: data
  logic [7:0] m_op, m_addr;
  logic       exp_overrun;
  int         last_rx_cyc = 0;
  logic [7:0] last_tx = 8'h00;
  bit         tx_hold = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_phase     = 0;
    exp_overrun = 1'b0;
    exp_q.delete();
  endfunction

  function automatic logic [31:0] model_flat();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  // Feed one accepted byte; gap is edges since the previous byte. Returns 1 if a reply is due.
  function automatic bit model_byte(input logic [7:0] b, input bit perr, input int gap);
    if (m_phase != 0 && gap > T) m_phase = 0;
    if (PCHK && perr) begin
      exp_q.push_back(8'h45);
      m_phase = 0;
      return 1'b1;
    end
    if (m_phase == 0) begin
      if (b == 8'h57 || b == 8'h52) begin
        m_op    = b;
        m_phase = 1;
        return 1'b0;
      end
      exp_q.push_back(8'h3F);
      return 1'b1;
    end
    if (m_phase == 1) begin
      m_addr = b;
      if (m_op == 8'h57) begin
        m_phase = 2;
        return 1'b0;
      end
      m_phase = 0;
      exp_q.push_back((b > 8'd3) ? 8'h3F : m_regs[b[1:0]]);
      return 1'b1;
    end
    m_phase = 0;
    if (m_addr > 8'd3) begin
      exp_q.push_back(8'h3F);
    end else begin
      m_regs[m_addr[1:0]] = b;
      exp_q.push_back(8'h4B);
    end
    return 1'b1;
  endfunction

  // ---------------- transmitter model ----------------
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      if (tx_start && tx_ready && !tx_hold && !rst) begin
        #1 tx_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  logic       prev_start = 1'b0;
  logic       prev_rdy = 1'b1;
  logic [7:0] held = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
      prev_rdy   = tx_ready;
    end else begin
      if (prev_start) begin
        check("tx_start_hold", 32'(tx_start), 32'(prev_rdy));
        if (tx_start) check("tx_data_stable", 32'(tx_data), 32'(held));
      end else if (tx_start) begin
        check("tx_start_rise_ready", 32'(prev_rdy), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL reply_unexpected: got 0x%0h, expected no reply", tx_data);
        end else begin
          check("reply", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        held    = tx_data;
        last_tx = tx_data;
      end
      if (!busy) begin
        check("idle_tx_start", 32'(tx_start), 32'd0);
        check("reg_out", reg_out, model_flat());
        check("overrun", 32'(overrun), 32'(exp_overrun));
      end
      prev_start = tx_start;
      prev_rdy   = tx_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit perr, input int gap, input int hold,
                           input bit to_model, output bit replied);
    while (cyc < last_rx_cyc + gap - 1) begin
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_perr  = perr;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    replied = 1'b0;
    if (to_model) replied = model_byte(b, perr, cyc - last_rx_cyc);
    last_rx_cyc = cyc;
    repeat (hold - 1) begin
      @(posedge clk); #1;
    end
    rx_ready = 1'b0;
    rx_perr  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) $display("  state at wait expiry: %s", dbg_state.name());
    check(name, {busy, 31'(exp_q.size())}, 32'd0);
  endtask

  task automatic send(input logic [7:0] b, input bit perr);
    bit r;
    send_byte(b, perr, 0, 1, 1'b1, r);
    if (r) wait_idle("cmd_done");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit r;
    int n;
    rst      = 1'b1;
    rx_ready = 1'b1;          // level held high across reset release
    rx_data  = 8'h57;
    rx_perr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_reg_out", reg_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_rx_new_at_release", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(posedge clk); #1;
    last_rx_cyc = cyc;

    // write then read back
    send(8'h57, 0); send(8'h02, 0); send(8'hA5, 0);
    check("wr_reply", 32'(last_tx), 32'h4B);
    check("wr_reg2", 32'(reg_out[23:16]), 32'hA5);
    send(8'h52, 0); send(8'h02, 0);
    check("rd_reply", 32'(last_tx), 32'hA5);

    // bad address, read and write
    send(8'h52, 0); send(8'h07, 0);
    check("bad_rd_reply", 32'(last_tx), 32'h3F);
    send(8'h57, 0); send(8'h05, 0); send(8'h11, 0);
    check("bad_wr_reply", 32'(last_tx), 32'h3F);
    check("bad_wr_regs", reg_out, 32'h00A5_0000);

    // unknown opcode
    send(8'h41, 0);
    check("unknown_op_reply", 32'(last_tx), 32'h3F);

    // timeout after opcode, then a fresh read
    send(8'h57, 0); send(8'h00, 0); send(8'h3C, 0);
    send(8'h57, 0);
    repeat (T + 2) begin
      @(posedge clk); #1;
    end
    check("to_idle", 32'(busy), 32'd0);
    send(8'h52, 0); send(8'h00, 0);
    check("to_next_read", 32'(last_tx), 32'h3C);

    // byte exactly on the expiry cycle is accepted
    send(8'h57, 0);
    send_byte(8'h01, 0, T, 1, 1'b1, r);
    send(8'h5A, 0);
    check("to_edge_reply", 32'(last_tx), 32'h4B);
    check("to_edge_reg1", 32'(reg_out[15:8]), 32'h5A);

    // one edge late: the command is dropped, the byte is a new (bad) opcode
    send(8'h57, 0);
    send_byte(8'h00, 0, T + 1, 1, 1'b1, r);
    if (r) wait_idle("late_done");
    check("to_late_reply", 32'(last_tx), 32'h3F);

    // timeout in data phase: late 'R' starts a read instead
    send(8'h57, 0); send(8'h02, 0);
    send_byte(8'h52, 0, T + 1, 1, 1'b1, r);
    send(8'h02, 0);
    check("to_data_reply", 32'(last_tx), 32'hA5);

    // overrun while SEND is held by a ready transmitter
    check("ovr_before", 32'(overrun), 32'd0);
    tx_hold = 1'b1;
    send_byte(8'h52, 0, 0, 1, 1'b1, r);
    send_byte(8'h01, 0, 0, 1, 1'b1, r);
    n = 0;
    while (!tx_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ovr_tx_start_up", 32'(tx_start), 32'd1);
    send_byte(8'h99, 0, 0, 1, 1'b0, r);
    exp_overrun = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("ovr_tx_start_held", 32'(tx_start), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    tx_hold = 1'b0;
    wait_idle("ovr_done");
    check("ovr_reply", 32'(last_tx), 32'h5A);

    // parity error on the address byte
    send(8'h57, 0);
    send(8'h01, 1);
`ifdef UART_CMD_PARITY_CHK_EN
    check("perr_reply", 32'(last_tx), 32'h45);
    check("perr_reg1", 32'(reg_out[15:8]), 32'h5A);
`else
    send(8'h77, 0);
    check("perr_ignored_reply", 32'(last_tx), 32'h4B);
    check("perr_ignored_reg1", 32'(reg_out[15:8]), 32'h77);
`endif

    // random command streams
    for (int c = 0; c < 60; c++) begin
      logic [7:0] bytes[3];
      int kind, prev_hold, hold, gap;
      bit perr;
      kind     = $urandom_range(0, 9);
      bytes[0] = (kind < 5) ? 8'h57 : (kind < 9) ? 8'h52 : 8'($urandom_range(0, 255));
      bytes[1] = 8'($urandom_range(0, 5));
      bytes[2] = 8'($urandom_range(0, 255));
      prev_hold = 1;
      for (int k = 0; k < 3; k++) begin
        hold = $urandom_range(1, 3);
        gap  = prev_hold + $urandom_range(1, 8);
        if (k > 0 && $urandom_range(0, 14) == 0) gap = T + $urandom_range(0, 3);
        perr = ($urandom_range(0, 9) == 0);
        send_byte(bytes[k], perr, gap, hold, 1'b1, r);
        prev_hold = hold;
        if (r) begin
          wait_idle("rand_done");
          break;
        end
      end
    end
    repeat (T + 5) begin
      @(posedge clk); #1;
    end

    // reset in the middle of a write command
    send(8'h57, 0); send(8'h00, 0);
    last_tx = 8'hFF;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_reg_out", reg_out, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h52, 0); send(8'h03, 0);
    check("post_rst_read", 32'(last_tx), 32'h00);

    // reset while SEND is stalled on a held transmitter
    tx_hold = 1'b1;
    send_byte(8'h52, 0, 0, 1, 1'b1, r);
    send_byte(8'h03, 0, 0, 1, 1'b1, r);
    repeat (4) begin
      @(posedge clk); #1;
    end
    tx_hold = 1'b0;
    do_reset();
    check("send_rst_busy", 32'(busy), 32'd0);
    check("send_rst_tx_start", 32'(tx_start), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog: got no end of test, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
